// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrating mux with a single registered output slot.
// Round-robin or fixed-priority grant; one word per cycle under full throughput.

module rr_arb_mux_lane #(
  parameter int WIDTH = 4
) (
  input  logic             gnt_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);
  assign data_o = data_i & {WIDTH{gnt_i}};
endmodule

module rr_arb_mux #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               prio_mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SELW-1:0]           ptr_q, ptr_d;
  logic [WIDTH-1:0]          data_q, data_d;
  logic [SELW-1:0]           sel_q, sel_d;
  logic                      vld_q, vld_d;

  logic                      found;
  logic [SELW-1:0]           gnt;
  logic [N-1:0]              gnt_oh;
  logic                      load;
  logic                      xfer;
  logic [N-1:0][WIDTH-1:0]   lane_data;
  logic [WIDTH-1:0]          sel_data;

  // Search order starts at ptr in round-robin mode, at 0 in fixed mode.
  always_comb begin
    logic [SELW-1:0] idx;
    found  = 1'b0;
    gnt    = '0;
    gnt_oh = '0;
    for (int i = 0; i < N; i++) begin
      idx = prio_mode ? SELW'(i) : SELW'((int'(ptr_q) + i) % N);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    if (found) gnt_oh[gnt] = 1'b1;
  end

  assign load     = !vld_q || out_ready;
  assign in_ready = (load && !rst) ? gnt_oh : '0;
  assign xfer     = |in_ready;

  rr_arb_mux_lane #(.WIDTH(WIDTH)) u_lane [N-1:0] (
    .gnt_i  (gnt_oh),
    .data_i (in_data),
    .data_o (lane_data)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) sel_data |= lane_data[k];
  end

  always_comb begin
    ptr_d  = ptr_q;
    data_d = data_q;
    sel_d  = sel_q;
    vld_d  = vld_q;
    if (xfer) begin
      ptr_d  = SELW'((int'(gnt) + 1) % N);
      data_d = sel_data;
      sel_d  = gnt;
      vld_d  = 1'b1;
    end else if (load) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      data_q <= '0;
      sel_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      data_q <= data_d;
      sel_q  <= sel_d;
      vld_q  <= vld_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (N=4, WIDTH=4); inputs driven and outputs
// sampled on the falling edge.

module tb_rr_arb_mux;
  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               prio_mode;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prio_mode (prio_mode),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; prio_mode = 1'b0;
    in_data = 16'h4321;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_in_ready2 got=%b exp=0000", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 4'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rst_out_sel got=%0d exp=0", out_sel); end
  endtask

  task automatic test_single();
    rst = 1'b0; in_valid = 4'b0100; in_data = 16'h0A00; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL single_in_ready got=%b exp=0100", in_ready); end
    @(negedge clk);
    in_valid = 4'b0000;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 4'hA) begin bad++; $display("FAIL single_data got=%h exp=a", out_data); end
    total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL single_sel got=%0d exp=2", out_sel); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 4'hA) begin bad++; $display("FAIL drain_hold_data got=%h exp=a", out_data); end
    total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL drain_hold_sel got=%0d exp=2", out_sel); end
  endtask

  task automatic test_round_robin();
    logic [SELW-1:0] exp_sel [5];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1; in_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0; prio_mode = 1'b0; in_valid = 4'b1111; in_data = 16'h4321; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%b exp=1", c, out_valid); end
      total++; if (out_sel !== exp_sel[c]) begin bad++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", c, out_sel, exp_sel[c]); end
      total++; if (out_data !== 4'(exp_sel[c]) + 4'd1) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", c, out_data, 4'(exp_sel[c]) + 4'd1); end
    end
  endtask

  // Entered with ptr=1; three fixed grants to ch1 leave ptr=2.
  task automatic test_mode_switch();
    prio_mode = 1'b1; in_valid = 4'b1110;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL fixed_sel[%0d] got=%0d exp=1", c, out_sel); end
      total++; if (out_data !== 4'h2) begin bad++; $display("FAIL fixed_data[%0d] got=%h exp=2", c, out_data); end
    end
    prio_mode = 1'b0;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL switch_in_ready got=%b exp=0100", in_ready); end
    @(negedge clk);
    total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL switch_sel got=%0d exp=2", out_sel); end
    total++; if (out_data !== 4'h3) begin bad++; $display("FAIL switch_data got=%h exp=3", out_data); end
  endtask

  // ptr=3 on entry; loading ch0 with 5 moves ptr to 1.
  task automatic test_backpressure();
    in_valid = 4'b0001; in_data = 16'h0005; out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_data !== 4'h5) begin bad++; $display("FAIL bp_load got=%h exp=5", out_data); end
    out_ready = 1'b0; in_valid = 4'b1111; in_data = 16'h8765;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", c, in_ready); end
      @(negedge clk);
      total++; if (out_data !== 4'h5) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=5", c, out_data); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, out_valid); end
      total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL bp_sel[%0d] got=%0d exp=0", c, out_sel); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
    @(negedge clk);
    total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL bp_release_sel got=%0d exp=1", out_sel); end
    total++; if (out_data !== 4'h6) begin bad++; $display("FAIL bp_release_data got=%h exp=6", out_data); end
  endtask

  // ptr=2 with a word held; reset must drop it and restart the search at ch0.
  task automatic test_reset_in_flight();
    in_valid = 4'b0000; rst = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rf_rst_ready got=%b exp=0000", in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 4'h0) begin bad++; $display("FAIL rf_data got=%h exp=0", out_data); end
    rst = 1'b0; in_valid = 4'b1111; in_data = 16'hDCBA;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL rf_first_ready got=%b exp=0001", in_ready); end
    @(negedge clk);
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rf_first_sel got=%0d exp=0", out_sel); end
    total++; if (out_data !== 4'hA) begin bad++; $display("FAIL rf_first_data got=%h exp=a", out_data); end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; prio_mode = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_mode_switch();
    test_backpressure();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
